// File: rtl/uart_core.sv
// Single-clock UART transceiver: baud-timed TX and a self-timed, mid-bit-sampling RX
// with configurable data length, runtime parity, stop-bit count and internal loopback.
`timescale 1ns/1ps
module uart_core #(
  parameter int DATA_LEN  = 8,
  parameter int CLK_DIV   = 16,
  parameter int STOP_BITS = 1
) (
  input  logic                clk1,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic                tx_done,
  output logic                txd,
  input  logic                rxd,
  input  logic                parity_en,
  input  logic                parity_type,
  input  logic                loopback,
  output logic [DATA_LEN-1:0] rx_data,
  output logic                rx_valid,
  output logic                parity_err,
  output logic                frame_err
);

  localparam int STOP_CYC = STOP_BITS * CLK_DIV;
  localparam int CNT_W    = $clog2(STOP_CYC) + 1;
  localparam int BIT_W    = $clog2(DATA_LEN) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_LEN - 1);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------- transmitter
  state_t              tx_state_reg, tx_state_next;
  logic [CNT_W-1:0]    tx_cnt_reg, tx_cnt_next;
  logic [BIT_W-1:0]    tx_bit_reg, tx_bit_next;
  logic [DATA_LEN-1:0] tx_shift_reg, tx_shift_next;
  logic                tx_par_en_reg, tx_par_en_next;
  logic                tx_par_reg, tx_par_next;
  logic                tx_line;

  always_ff @(posedge clk1) begin
    if (rst) begin
      tx_state_reg  <= S_IDLE;
      tx_cnt_reg    <= '0;
      tx_bit_reg    <= '0;
      tx_shift_reg  <= '0;
      tx_par_en_reg <= 1'b0;
      tx_par_reg    <= 1'b0;
    end else begin
      tx_state_reg  <= tx_state_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_bit_reg    <= tx_bit_next;
      tx_shift_reg  <= tx_shift_next;
      tx_par_en_reg <= tx_par_en_next;
      tx_par_reg    <= tx_par_next;
    end
  end

  always_comb begin
    tx_state_next  = tx_state_reg;
    tx_cnt_next    = tx_cnt_reg;
    tx_bit_next    = tx_bit_reg;
    tx_shift_next  = tx_shift_reg;
    tx_par_en_next = tx_par_en_reg;
    tx_par_next    = tx_par_reg;
    tx_line        = 1'b1;
    tx_ready       = 1'b0;
    tx_done        = 1'b0;
    case (tx_state_reg)
      S_IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          // Parity is computed once here so mid-frame config changes are ignored.
          tx_state_next  = S_START;
          tx_cnt_next    = '0;
          tx_shift_next  = tx_data;
          tx_par_en_next = parity_en;
          tx_par_next    = (^tx_data) ^ parity_type;
        end
      end
      S_START: begin
        tx_line = 1'b0;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_state_next = S_DATA;
          tx_cnt_next   = '0;
          tx_bit_next   = '0;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      S_DATA: begin
        tx_line = tx_shift_reg[0];
        if (tx_cnt_reg == BIT_LAST) begin
          tx_cnt_next   = '0;
          tx_shift_next = {1'b0, tx_shift_reg[DATA_LEN-1:1]};
          if (tx_bit_reg == DATA_LAST) begin
            tx_state_next = tx_par_en_reg ? S_PARITY : S_STOP;
          end else begin
            tx_bit_next = tx_bit_reg + BIT_ONE;
          end
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      S_PARITY: begin
        tx_line = tx_par_reg;
        if (tx_cnt_reg == BIT_LAST) begin
          tx_state_next = S_STOP;
          tx_cnt_next   = '0;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      S_STOP: begin
        if (tx_cnt_reg == STOP_LAST) begin
          tx_done       = 1'b1;
          tx_state_next = S_IDLE;
          tx_cnt_next   = '0;
        end else begin
          tx_cnt_next = tx_cnt_reg + CNT_ONE;
        end
      end
      default: tx_state_next = S_IDLE;
    endcase
  end

  assign txd = loopback ? 1'b1 : tx_line;

  // ------------------------------------------------------------------- receiver
  logic sync1_reg, sync2_reg;
  logic rx_prev_reg;
  logic rx_line;

  always_ff @(posedge clk1) begin
    if (rst) begin
      sync1_reg   <= 1'b1;
      sync2_reg   <= 1'b1;
      rx_prev_reg <= 1'b1;
    end else begin
      sync1_reg   <= rxd;
      sync2_reg   <= sync1_reg;
      rx_prev_reg <= rx_line;
    end
  end

  // Loopback taps the internal TX line directly; it is already in this clock domain.
  assign rx_line = loopback ? tx_line : sync2_reg;

  state_t              rx_state_reg, rx_state_next;
  logic [CNT_W-1:0]    rx_cnt_reg, rx_cnt_next;
  logic [BIT_W-1:0]    rx_bit_reg, rx_bit_next;
  logic [DATA_LEN-1:0] rx_shift_reg, rx_shift_next;
  logic                rx_par_en_reg, rx_par_en_next;
  logic                rx_par_type_reg, rx_par_type_next;
  logic                rx_par_bit_reg, rx_par_bit_next;
  logic [DATA_LEN-1:0] rx_data_reg, rx_data_next;
  logic                rx_valid_reg, rx_valid_next;
  logic                parity_err_reg, parity_err_next;
  logic                frame_err_reg, frame_err_next;

  always_ff @(posedge clk1) begin
    if (rst) begin
      rx_state_reg    <= S_IDLE;
      rx_cnt_reg      <= '0;
      rx_bit_reg      <= '0;
      rx_shift_reg    <= '0;
      rx_par_en_reg   <= 1'b0;
      rx_par_type_reg <= 1'b0;
      rx_par_bit_reg  <= 1'b0;
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      parity_err_reg  <= 1'b0;
      frame_err_reg   <= 1'b0;
    end else begin
      rx_state_reg    <= rx_state_next;
      rx_cnt_reg      <= rx_cnt_next;
      rx_bit_reg      <= rx_bit_next;
      rx_shift_reg    <= rx_shift_next;
      rx_par_en_reg   <= rx_par_en_next;
      rx_par_type_reg <= rx_par_type_next;
      rx_par_bit_reg  <= rx_par_bit_next;
      rx_data_reg     <= rx_data_next;
      rx_valid_reg    <= rx_valid_next;
      parity_err_reg  <= parity_err_next;
      frame_err_reg   <= frame_err_next;
    end
  end

  always_comb begin
    rx_state_next    = rx_state_reg;
    rx_cnt_next      = rx_cnt_reg;
    rx_bit_next      = rx_bit_reg;
    rx_shift_next    = rx_shift_reg;
    rx_par_en_next   = rx_par_en_reg;
    rx_par_type_next = rx_par_type_reg;
    rx_par_bit_next  = rx_par_bit_reg;
    rx_data_next     = rx_data_reg;
    rx_valid_next    = 1'b0;
    parity_err_next  = parity_err_reg;
    frame_err_next   = frame_err_reg;
    case (rx_state_reg)
      S_IDLE: begin
        // A start needs a high-to-low transition, so a line stuck low after a
        // framing error cannot re-trigger until it has been seen high again.
        if (rx_prev_reg && !rx_line) begin
          rx_state_next    = S_START;
          rx_cnt_next      = '0;
          rx_par_en_next   = parity_en;
          rx_par_type_next = parity_type;
        end
      end
      S_START: begin
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_line ? S_IDLE : S_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      S_DATA: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_line, rx_shift_reg[DATA_LEN-1:1]};
          if (rx_bit_reg == DATA_LAST) begin
            rx_state_next = rx_par_en_reg ? S_PARITY : S_STOP;
          end else begin
            rx_bit_next = rx_bit_reg + BIT_ONE;
          end
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      S_PARITY: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next     = '0;
          rx_par_bit_next = rx_line;
          rx_state_next   = S_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      S_STOP: begin
        if (rx_cnt_reg == BIT_LAST) begin
          rx_cnt_next     = '0;
          rx_state_next   = S_IDLE;
          rx_valid_next   = 1'b1;
          rx_data_next    = rx_shift_reg;
          frame_err_next  = ~rx_line;
          parity_err_next = rx_par_en_reg &&
                            (rx_par_bit_reg != ((^rx_shift_reg) ^ rx_par_type_reg));
        end else begin
          rx_cnt_next = rx_cnt_reg + CNT_ONE;
        end
      end
      default: rx_state_next = S_IDLE;
    endcase
  end

  assign rx_data    = rx_data_reg;
  assign rx_valid   = rx_valid_reg;
  assign parity_err = parity_err_reg;
  assign frame_err  = frame_err_reg;

endmodule

// File: tb/tb_uart_core.sv
// Bench for uart_core: waveform-level TX model, expected-frame queue for RX, randomized traffic.
`timescale 1ns/1ps
module tb_uart_core;
  localparam int DL  = 8;
  localparam int DIV = 16;

  logic clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // DUT A: STOP_BITS=1, carries RX and loopback traffic
  logic          rst_a, tx_valid_a, rxd, parity_en, parity_type, loopback;
  logic [DL-1:0] tx_data_a;
  logic          tx_ready_a, tx_done_a, txd_a, rx_valid_a, parity_err_a, frame_err_a;
  logic [DL-1:0] rx_data_a;
  // DUT B: STOP_BITS=2, TX only
  logic          rst_b, tx_valid_b, rxd_b, pen_b, ptype_b, loop_b;
  logic [DL-1:0] tx_data_b;
  logic          tx_ready_b, tx_done_b, txd_b, rx_valid_b, parity_err_b, frame_err_b;
  logic [DL-1:0] rx_data_b;

  uart_core #(.DATA_LEN(DL), .CLK_DIV(DIV), .STOP_BITS(1)) dut_a (
    .clk1(clk1), .rst(rst_a), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
    .tx_ready(tx_ready_a), .tx_done(tx_done_a), .txd(txd_a), .rxd(rxd),
    .parity_en(parity_en), .parity_type(parity_type), .loopback(loopback),
    .rx_data(rx_data_a), .rx_valid(rx_valid_a), .parity_err(parity_err_a),
    .frame_err(frame_err_a));

  uart_core #(.DATA_LEN(DL), .CLK_DIV(DIV), .STOP_BITS(2)) dut_b (
    .clk1(clk1), .rst(rst_b), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
    .tx_ready(tx_ready_b), .tx_done(tx_done_b), .txd(txd_b), .rxd(rxd_b),
    .parity_en(pen_b), .parity_type(ptype_b), .loopback(loop_b),
    .rx_data(rx_data_b), .rx_valid(rx_valid_b), .parity_err(parity_err_b),
    .frame_err(frame_err_b));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // TX model: position inside the current frame (-1 = idle) plus the frame's latched config.
  int            pos[2];
  logic [DL-1:0] md[2];
  logic          mpen[2], mptype[2];
  int            stops[2];
  logic          model_on = 1'b0;

  function automatic int frame_len(input int k);
    return (1 + DL + int'(mpen[k]) + stops[k]) * DIV;
  endfunction

  function automatic logic exp_line(input int k);
    int b;
    b = pos[k] / DIV;
    if (b == 0) return 1'b0;
    if (b <= DL) return md[k][b-1];
    if (b == DL + 1 && mpen[k]) return (^md[k]) ^ mptype[k];
    return 1'b1;
  endfunction

  typedef struct packed {
    logic [DL-1:0] d;
    logic          pe;
    logic          fe;
  } rx_exp_t;
  rx_exp_t rxq[$];
  rx_exp_t last_rx;
  rx_exp_t cur;
  int      rx_count = 0;

  logic          a_txd, a_done, a_ready, e_txd, e_done, e_ready, v, r, pe, pt;
  logic [DL-1:0] dd;
  logic          busy;

  always @(negedge clk1) begin
    if (model_on) begin
      for (int k = 0; k < 2; k++) begin
        a_txd   = (k == 0) ? txd_a      : txd_b;
        a_done  = (k == 0) ? tx_done_a  : tx_done_b;
        a_ready = (k == 0) ? tx_ready_a : tx_ready_b;
        v       = (k == 0) ? tx_valid_a : tx_valid_b;
        r       = (k == 0) ? rst_a      : rst_b;
        dd      = (k == 0) ? tx_data_a  : tx_data_b;
        pe      = (k == 0) ? parity_en  : pen_b;
        pt      = (k == 0) ? parity_type : ptype_b;
        busy    = pos[k] >= 0;
        e_txd   = (k == 0 && loopback) ? 1'b1 : (busy ? exp_line(k) : 1'b1);
        e_done  = busy && (pos[k] == frame_len(k) - 1);
        e_ready = !busy;
        check($sformatf("txd%0d", k), 32'(a_txd), 32'(e_txd));
        check($sformatf("tx_done%0d", k), 32'(a_done), 32'(e_done));
        check($sformatf("tx_ready%0d", k), 32'(a_ready), 32'(e_ready));
        if (r) pos[k] = -1;
        else if (busy) pos[k] = (pos[k] == frame_len(k) - 1) ? -1 : pos[k] + 1;
        else if (v) begin
          pos[k] = 0; md[k] = dd; mpen[k] = pe; mptype[k] = pt;
        end
      end
      if (rx_valid_a) begin
        rx_count++;
        if (rxq.size() == 0) begin
          check("rx_valid_unexpected", 32'(rx_valid_a), 32'd0);
        end else begin
          cur = rxq.pop_front();
          last_rx = cur;
        end
      end
      check("rx_data", 32'(rx_data_a), 32'(last_rx.d));
      check("parity_err", 32'(parity_err_a), 32'(last_rx.pe));
      check("frame_err", 32'(frame_err_a), 32'(last_rx.fe));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic send_a(input logic [DL-1:0] d);
    int t;
    t = 0;
    while (!tx_ready_a && t < 1000) begin
      tick(1);
      t++;
    end
    if (!tx_ready_a) check("send_a_timeout", 32'(tx_ready_a), 32'd1);
    tx_data_a  = d;
    tx_valid_a = 1'b1;
    tick(1);
    tx_valid_a = 1'b0;
  endtask

  task automatic drive_rx(input logic [DL-1:0] d, input logic pen, input logic ptype,
                          input logic bad_par, input logic stop_low);
    rx_exp_t e;
    parity_en   = pen;
    parity_type = ptype;
    e.d  = d;
    e.pe = pen & bad_par;
    e.fe = stop_low;
    rxq.push_back(e);
    rxd = 1'b0;
    tick(DIV);
    for (int i = 0; i < DL; i++) begin
      rxd = d[i];
      tick(DIV);
    end
    if (pen) begin
      rxd = (^d) ^ ptype ^ bad_par;
      tick(DIV);
    end
    rxd = ~stop_low;
    tick(DIV);
    rxd = 1'b1;
    tick(2 * DIV);
    check("rx_frame_delivered", 32'(rxq.size()), 32'd0);
    rxq.delete();
  endtask

  int            done_n, ready_n, second_n, c0;
  logic [9:0]    got_bits, exp_bits;
  logic          par_bit, stop_bit;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stops[0] = 1; stops[1] = 2; pos[0] = -1; pos[1] = -1;
    last_rx = '0;
    rst_a = 1; rst_b = 1; tx_valid_a = 0; tx_valid_b = 0; tx_data_a = 0; tx_data_b = 0;
    rxd = 1; rxd_b = 1; parity_en = 0; parity_type = 0; loopback = 0;
    pen_b = 0; ptype_b = 0; loop_b = 0;
    tick(3);
    check("rst_txd", 32'(txd_a), 32'd1);
    check("rst_tx_ready", 32'(tx_ready_a), 32'd1);
    check("rst_tx_done", 32'(tx_done_a), 32'd0);
    check("rst_rx_data", 32'(rx_data_a), 32'd0);
    check("rst_rx_valid", 32'(rx_valid_a), 32'd0);
    check("rst_errs", 32'({parity_err_a, frame_err_a}), 32'd0);
    rst_a = 0; rst_b = 0;
    model_on = 1'b1;
    tick(2);

    // 0xA5, 8N1: mid-bit levels and done/ready timing
    send_a(8'hA5);
    done_n = -1; ready_n = -1; got_bits = '0;
    for (int n = 1; n <= 165; n++) begin
      @(negedge clk1);
      if (n >= 8 && (n - 8) % DIV == 0 && (n - 8) / DIV < 10) got_bits[(n - 8) / DIV] = txd_a;
      if (tx_done_a && done_n < 0) done_n = n;
      if (tx_ready_a && ready_n < 0) ready_n = n;
    end
    exp_bits = 10'b1101001010;
    check("a5_bits", 32'(got_bits), 32'(exp_bits));
    check("a5_done_cycle", 32'(done_n), 32'd160);
    check("a5_ready_cycle", 32'(ready_n), 32'd161);
    tick(3);

    // 0x3C, even parity on the pin
    parity_en = 1; parity_type = 0;
    send_a(8'h3C);
    done_n = -1;
    for (int n = 1; n <= 180; n++) begin
      @(negedge clk1);
      if (n == 8 + 9 * DIV) par_bit = txd_a;
      if (n == 8 + 10 * DIV) stop_bit = txd_a;
      if (tx_done_a && done_n < 0) done_n = n;
    end
    check("3c_parity_bit", 32'(par_bit), 32'd0);
    check("3c_stop_bit", 32'(stop_bit), 32'd1);
    check("3c_done_cycle", 32'(done_n), 32'd176);
    tick(3);

    // Loopback 0x3C with even parity
    loopback = 1;
    tick(2);
    rxq.push_back('{d: 8'h3C, pe: 1'b0, fe: 1'b0});
    send_a(8'h3C);
    tick(200);
    check("lb_rx_data", 32'(rx_data_a), 32'h3C);
    check("lb_errs", 32'({parity_err_a, frame_err_a}), 32'd0);
    check("lb_delivered", 32'(rxq.size()), 32'd0);
    rxq.delete();
    loopback = 0;
    tick(4);

    // Parity error: odd configured, even bit driven
    drive_rx(8'h55, 1'b1, 1'b1, 1'b1, 1'b0);
    check("p55_data", 32'(rx_data_a), 32'h55);
    check("p55_parity_err", 32'(parity_err_a), 32'd1);

    // Framing error then recovery
    drive_rx(8'h81, 1'b0, 1'b0, 1'b0, 1'b1);
    check("f81_frame_err", 32'(frame_err_a), 32'd1);
    drive_rx(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
    check("f81_recover_frame_err", 32'(frame_err_a), 32'd0);
    check("f81_recover_data", 32'(rx_data_a), 32'h81);

    // Short glitch must be rejected
    c0 = rx_count;
    rxd = 0;
    tick(6);
    rxd = 1;
    tick(3 * DIV);
    check("glitch_no_valid", 32'(rx_count), 32'(c0));
    drive_rx(8'h12, 1'b0, 1'b0, 1'b0, 1'b0);
    check("after_glitch_data", 32'(rx_data_a), 32'h12);

    // Back-to-back on the 2-stop-bit instance, then reset mid-data
    tx_data_b = 8'h01; tx_valid_b = 1;
    tick(1);
    tx_data_b = 8'hFF;
    done_n = -1; second_n = -1;
    for (int n = 1; n <= 226; n++) begin
      @(negedge clk1);
      if (tx_done_b && done_n < 0) done_n = n;
      if (tx_ready_b && second_n < 0) second_n = n;
    end
    check("b2b_done_cycle", 32'(done_n), 32'd176);
    check("b2b_second_accept", 32'(second_n), 32'd177);
    @(posedge clk1); #1;
    rst_b = 1; tx_valid_b = 0;
    tick(1);
    check("rst_mid_txd", 32'(txd_b), 32'd1);
    check("rst_mid_ready", 32'(tx_ready_b), 32'd1);
    check("rst_mid_done", 32'(tx_done_b), 32'd0);
    rst_b = 0;
    tick(4);

    // Randomized: independent TX traffic and external RX frames at once
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          send_a(DL'($urandom));
          tick($urandom_range(0, 20));
        end
      end
      begin
        for (int i = 0; i < 15; i++) begin
          drive_rx(DL'($urandom), 1'($urandom), 1'($urandom),
                   ($urandom % 4) == 0, ($urandom % 5) == 0);
          tick($urandom_range(0, 10));
        end
      end
    join
    tick(250);

    // Randomized loopback frames
    loopback = 1;
    tick(2);
    for (int i = 0; i < 8; i++) begin
      parity_en   = 1'($urandom);
      parity_type = 1'($urandom);
      cur.d = DL'($urandom); cur.pe = 1'b0; cur.fe = 1'b0;
      rxq.push_back(cur);
      send_a(cur.d);
      tick(200);
      check("lb_rand_delivered", 32'(rxq.size()), 32'd0);
      rxq.delete();
    end
    loopback = 0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Single-clock, parametrised UART transceiver: transmitter, receiver and baud timing in one block.
- Generalises the two-clock TX/RX pair to a configurable frame: data length, runtime parity, stop-bit count and loopback.
- Replaces the `tx_done`-coupled receiver with a self-timed, mid-bit-sampling RX that detects frame and parity errors.
- Sits between a byte-level host interface and the chip's serial pins.

Parameters:
- DATA_LEN, 8, data bits per frame; legal 5..9.
- CLK_DIV, 16, `clk1` cycles per bit; legal >= 4.
- STOP_BITS, 1, stop bits transmitted; legal 1 or 2. RX checks only the first stop bit.

Ports:
- clk1  input  1  system clock; all logic on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_LEN  word to transmit.
- tx_valid  input  1  host offers `tx_data`.
- tx_ready  output  1  TX idle; can accept a word.
- tx_done  output  1  one-cycle pulse at the end of the last stop bit.
- txd  output  1  serial out; idle high.
- rxd  input  1  serial in; asynchronous.
- parity_en  input  1  1 = parity bit present, TX and RX.
- parity_type  input  1  0 = even, 1 = odd.
- loopback  input  1  1 = RX fed internally from the TX line.
- rx_data  output  DATA_LEN  last received word.
- rx_valid  output  1  one-cycle pulse when a frame completes.
- parity_err  output  1  parity mismatch on the last frame.
- frame_err  output  1  stop bit sampled low on the last frame.

Behaviour:
- Reset:
  - `txd`=1, `tx_ready`=1, `tx_done`=0.
  - `rx_data`=0, `rx_valid`=0, `parity_err`=0, `frame_err`=0.
  - Both FSMs go to IDLE; all counters cleared.
  - Reset mid-frame aborts immediately. No partial `rx_valid`. `txd` returns high on the next cycle.
- Configuration sampling: `parity_en` and `parity_type` are sampled at TX accept and at RX start detect. Changes mid-frame do not affect that frame.
- TX FSM: IDLE -> START -> DATA -> PARITY (only if `parity_en`) -> STOP -> IDLE.
  - Handshake: accept when `tx_valid && tx_ready`. On the accept edge, latch `tx_data` and drop `tx_ready`.
  - `txd` goes low on the cycle after accept.
  - Each bit lasts exactly CLK_DIV cycles. Data is sent LSB first.
  - Parity bit = XOR of data bits, XOR `parity_type`.
  - STOP lasts STOP_BITS*CLK_DIV cycles, `txd`=1.
  - `tx_done` pulses in the last cycle of STOP. `tx_ready` returns to 1 on the following cycle.
  - Frame length = (1 + DATA_LEN + `parity_en` + STOP_BITS)*CLK_DIV cycles.
  - Back-to-back: `tx_valid` held high gives a new START immediately after `tx_ready` rises; no extra idle bit.
- RX input path: `rxd` passes through a 2-flop synchroniser (2-cycle latency). In loopback mode the internal TX line bypasses the synchroniser; `txd` is forced to 1 while `loopback`=1.
- RX FSM: IDLE -> START -> DATA -> PARITY (only if `parity_en`) -> STOP -> IDLE.
  - IDLE: a falling edge on the synchronised line enters START.
  - START: wait CLK_DIV/2 cycles, then resample. If high, treat as a glitch and return to IDLE with no outputs. If low, continue.
  - Sampling: every subsequent bit is sampled CLK_DIV cycles after the previous sample, i.e. mid-bit. Data is shifted LSB first.
  - PARITY: compare the received bit against the computed parity.
  - STOP: sample once. `frame_err` = sample==0.
  - At STOP sample: `rx_data` updated, `parity_err`/`frame_err` updated (`parity_err`=0 when parity disabled), `rx_valid` pulses for 1 cycle. FSM returns to IDLE on the same edge.
- After a frame error, a new start is not re-armed until the line has been seen high.
- `rx_data` and the error flags hold until the next completed frame.
- There is no RX buffer: the host must take `rx_data` within one frame time.
- TX and RX are fully independent; simultaneous TX accept and RX completion are both honoured.

Test Plan:
- Reset; DATA_LEN=8, CLK_DIV=16, parity off; send 0xA5 -> `txd` reads 0,1,0,1,0,0,1,0,1,1, each level held 16 cycles. `tx_done` fires at cycle 160 after accept; `tx_ready`=1 at 161.
- Loopback, `parity_en`=1, `parity_type`=0, send 0x3C -> parity bit 0 on the TX line. `rx_valid` pulse with `rx_data`=0x3C, `parity_err`=0, `frame_err`=0.
- External `rxd` frame 0x55 with odd parity configured but even parity bit driven -> `rx_data`=0x55, `parity_err`=1.
- External frame 0x81, stop bit driven low -> `frame_err`=1. A following valid 0x81 after the line goes high -> `frame_err`=0.
- `rxd` low pulse of 6 cycles (< CLK_DIV/2) -> no `rx_valid`, FSM back in IDLE. A subsequent valid 0x12 is received correctly.
- Hold `tx_valid` with 0x01 then 0xFF back-to-back; STOP_BITS=2 -> no gap between frames, each frame 176 cycles. Assert `rst` mid-data of the second frame -> `txd`=1 and `tx_ready`=1 the next cycle, no `tx_done`.
